time_setter: RTL and testbench
==============================

TIME_SETTER -- requirements
Module: time_setter

Interface
REQ-001 Parameter MIN_TENS_MAX, default 9, meaning the highest value of the minutes-tens digit before wrap.
REQ-002 Parameter DIGIT_W, default 4, meaning the width of each BCD digit bus.
REQ-003 Port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 Port reset  input  1  synchronous, active-low reset (asserted when 0, sampled on rising clk).
REQ-005 Port btn_next  input  1  one-cycle pulse, already debounced; advances the selected digit.
REQ-006 Port btn_up  input  1  one-cycle pulse; increments the selected digit.
REQ-007 Port btn_down  input  1  one-cycle pulse; decrements the selected digit.
REQ-008 Port btn_start  input  1  one-cycle pulse; commits the entry and starts the timer, or acknowledges the alarm.
REQ-009 Port btn_clear  input  1  one-cycle pulse; aborts or clears.
REQ-010 Port timer_done  input  1  level from the downstream countdown chain, high when all digits are zero.
REQ-011 Port sec_ones, sec_tens, min_ones, min_tens  output  DIGIT_W each  registered BCD start value, presented to the counter chain start_count inputs.
REQ-012 Port load  output  1  registered one-cycle pulse; the counter chain loads the digits.
REQ-013 Port run_enable  output  1  registered enable for the counter chain tick gating.
REQ-014 Port edit_sel  output  2  selected digit: 0 = sec_ones, 1 = sec_tens, 2 = min_ones, 3 = min_tens.
REQ-015 Port editing  output  1  high while in EDIT; used for display blinking.
REQ-016 Port alarm  output  1  high while in ALARM.

Function
REQ-017 FSM states: EDIT, LOAD, RUN, ALARM. The only transitions are the ones below.
REQ-018 EDIT priority when pulses coincide: btn_clear > btn_start > btn_up > btn_down > btn_next. Exactly one action per cycle.
REQ-019 EDIT btn_clear: all four digits go to 0 and edit_sel goes to 0 on the next edge. State stays EDIT.
REQ-020 EDIT btn_up: the selected digit increments with wrap. Ranges: sec_ones 9->0, sec_tens 5->0, min_ones 9->0, min_tens MIN_TENS_MAX->0. The other digits are unchanged; there is no carry.
REQ-021 EDIT btn_down: the selected digit decrements with wrap, 0 -> its range maximum per REQ-020. There is no borrow.
REQ-022 EDIT btn_next: edit_sel goes 0->1->2->3->0.
REQ-023 EDIT btn_start with all digits 0: ignored, state stays EDIT. With any digit nonzero: next state is LOAD.
REQ-024 LOAD: lasts exactly one cycle, load=1, run_enable=0. The digits are stable. Next state is RUN unconditionally. Buttons are ignored.
REQ-025 RUN: run_enable=1, load=0. btn_up, btn_down, btn_next and btn_start are ignored.
REQ-026 RUN btn_clear: next state is EDIT with the digits and edit_sel retained. btn_clear takes priority over timer_done in the same cycle.
REQ-027 RUN timer_done=1 (no clear): next state is ALARM. timer_done is ignored in every other state.
REQ-028 ALARM: alarm=1, run_enable=0. btn_start or btn_clear returns to EDIT with the digits retained, which gives repeat-timer behaviour.
REQ-029 Outputs are Moore outputs from state registers: editing=(EDIT), load=(LOAD), run_enable=(RUN), alarm=(ALARM). There is no combinational input-to-output path.
REQ-030 The digit registers change only in EDIT and never leave their legal BCD ranges.

Reset
REQ-031 With reset=0 at a rising edge: state=EDIT, all digits=0, edit_sel=0, load=0, run_enable=0, alarm=0, editing=1.
REQ-032 Reset overrides all inputs in every state, including mid-LOAD and mid-RUN. load is never high in the cycle after reset is asserted.

Verification
REQ-033 Edit wrap: after reset, btn_down -> sec_ones=9. btn_next, btn_up x6 -> sec_tens=0 (wrapped after 5), edit_sel=1.
REQ-034 Start ignored at zero: after reset, btn_start -> state stays EDIT, load never pulses over 5 cycles.
REQ-035 Load handshake: digits 0,3,0,1 (min_tens..sec_ones), btn_start -> load=1 for exactly one cycle, run_enable=1 from the following cycle, digits unchanged.
REQ-036 Completion: in RUN, drive timer_done=1 -> alarm=1 and run_enable=0 on the next cycle. btn_start -> EDIT with digits still 0,3,0,1.
REQ-037 Simultaneous events: in RUN, btn_clear and timer_done together -> EDIT, alarm stays 0. In EDIT, btn_up and btn_down together -> increment only.
REQ-038 Reset mid-run: reset=0 during RUN -> all outputs at REQ-031 values on the next edge, digits=0.

Source files
------------

// File: rtl/time_setter.sv
// Countdown-timer front end: BCD digit entry, load handshake to the counter
// chain, run gating and alarm acknowledge, all as registered Moore outputs.
module time_setter #(
    parameter int unsigned MIN_TENS_MAX = 9,
    parameter int unsigned DIGIT_W      = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               btn_next,
    input  logic               btn_up,
    input  logic               btn_down,
    input  logic               btn_start,
    input  logic               btn_clear,
    input  logic               timer_done,
    output logic [DIGIT_W-1:0] sec_ones,
    output logic [DIGIT_W-1:0] sec_tens,
    output logic [DIGIT_W-1:0] min_ones,
    output logic [DIGIT_W-1:0] min_tens,
    output logic               load,
    output logic               run_enable,
    output logic [1:0]         edit_sel,
    output logic               editing,
    output logic               alarm
);

    typedef enum logic [1:0] {
        ST_EDIT,
        ST_LOAD,
        ST_RUN,
        ST_ALARM
    } state_t;

    state_t             state_q, state_d;
    logic [DIGIT_W-1:0] digit_q [4];
    logic [DIGIT_W-1:0] digit_d [4];
    logic [1:0]         sel_q, sel_d;
    logic               load_q, run_q, editing_q, alarm_q;

    function automatic logic [DIGIT_W-1:0] digit_max(input logic [1:0] idx);
        case (idx)
            2'd1:    digit_max = DIGIT_W'(5);
            2'd3:    digit_max = DIGIT_W'(MIN_TENS_MAX);
            default: digit_max = DIGIT_W'(9);
        endcase
    endfunction

    logic any_nonzero;
    always_comb begin
        any_nonzero = 1'b0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (digit_q[i] != '0) any_nonzero = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        for (int unsigned i = 0; i < 4; i++) digit_d[i] = digit_q[i];

        case (state_q)
            ST_EDIT: begin
                // Fixed priority: clear > start > up > down > next.
                if (btn_clear) begin
                    for (int unsigned i = 0; i < 4; i++) digit_d[i] = '0;
                    sel_d = '0;
                end else if (btn_start) begin
                    if (any_nonzero) state_d = ST_LOAD;
                end else if (btn_up) begin
                    digit_d[sel_q] = (digit_q[sel_q] >= digit_max(sel_q)) ? '0
                                   : digit_q[sel_q] + DIGIT_W'(1);
                end else if (btn_down) begin
                    digit_d[sel_q] = (digit_q[sel_q] == '0) ? digit_max(sel_q)
                                   : digit_q[sel_q] - DIGIT_W'(1);
                end else if (btn_next) begin
                    sel_d = sel_q + 2'd1;
                end
            end
            ST_LOAD:  state_d = ST_RUN;
            ST_RUN: begin
                if (btn_clear)       state_d = ST_EDIT;
                else if (timer_done) state_d = ST_ALARM;
            end
            ST_ALARM: begin
                if (btn_start || btn_clear) state_d = ST_EDIT;
            end
            default:  state_d = ST_EDIT;
        endcase
    end

    // Output flags are registered from the next state so they stay Moore.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= ST_EDIT;
            sel_q     <= '0;
            for (int unsigned i = 0; i < 4; i++) digit_q[i] <= '0;
            load_q    <= 1'b0;
            run_q     <= 1'b0;
            editing_q <= 1'b1;
            alarm_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            for (int unsigned i = 0; i < 4; i++) digit_q[i] <= digit_d[i];
            load_q    <= (state_d == ST_LOAD);
            run_q     <= (state_d == ST_RUN);
            editing_q <= (state_d == ST_EDIT);
            alarm_q   <= (state_d == ST_ALARM);
        end
    end

    assign sec_ones   = digit_q[0];
    assign sec_tens   = digit_q[1];
    assign min_ones   = digit_q[2];
    assign min_tens   = digit_q[3];
    assign edit_sel   = sel_q;
    assign load       = load_q;
    assign run_enable = run_q;
    assign editing    = editing_q;
    assign alarm      = alarm_q;

endmodule

// File: tb/tb_time_setter.sv
// Scoreboard bench for time_setter: directed scenarios then random button traffic,
// expected snapshots from a mode/modular-arithmetic reference model.
module tb_time_setter;

    localparam int TB_MT = 6;

    logic       clk = 1'b0;
    logic       reset, btn_next, btn_up, btn_down, btn_start, btn_clear, timer_done;
    logic [3:0] sec_ones, sec_tens, min_ones, min_tens;
    logic       load, run_enable, editing, alarm;
    logic [1:0] edit_sel;

    always #5 clk = ~clk;

    time_setter #(.MIN_TENS_MAX(TB_MT), .DIGIT_W(4)) dut (
        .clk(clk), .reset(reset), .btn_next(btn_next), .btn_up(btn_up),
        .btn_down(btn_down), .btn_start(btn_start), .btn_clear(btn_clear),
        .timer_done(timer_done), .sec_ones(sec_ones), .sec_tens(sec_tens),
        .min_ones(min_ones), .min_tens(min_tens), .load(load),
        .run_enable(run_enable), .edit_sel(edit_sel), .editing(editing),
        .alarm(alarm)
    );

    typedef struct {
        string name;
        int    d [4];
        int    sel;
        int    mode; // 0 edit, 1 load, 2 run, 3 alarm
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    int m_d [4];
    int m_sel;
    int m_mode;

    function automatic int range_top(int i);
        return (i == 3) ? TB_MT : ((i == 1) ? 5 : 9);
    endfunction

    function automatic void model_step(bit rst, bit n, bit u, bit dn, bit s, bit c, bit td);
        if (!rst) begin
            m_d = '{0, 0, 0, 0};
            m_sel = 0;
            m_mode = 0;
            return;
        end
        if (m_mode == 0) begin
            if (c) begin
                m_d = '{0, 0, 0, 0};
                m_sel = 0;
            end else if (s) begin
                if (m_d[0] + m_d[1] + m_d[2] + m_d[3] > 0) m_mode = 1;
            end else if (u) begin
                m_d[m_sel] = (m_d[m_sel] + 1) % (range_top(m_sel) + 1);
            end else if (dn) begin
                m_d[m_sel] = (m_d[m_sel] + range_top(m_sel)) % (range_top(m_sel) + 1);
            end else if (n) begin
                m_sel = (m_sel + 1) % 4;
            end
        end else if (m_mode == 1) begin
            m_mode = 2;
        end else if (m_mode == 2) begin
            if (c) m_mode = 0;
            else if (td) m_mode = 3;
        end else begin
            if (s || c) m_mode = 0;
        end
    endfunction

    task automatic step(string name, bit rst, bit n, bit u, bit dn, bit s, bit c, bit td);
        exp_t e;
        @(negedge clk);
        reset = rst; btn_next = n; btn_up = u; btn_down = dn;
        btn_start = s; btn_clear = c; timer_done = td;
        model_step(rst, n, u, dn, s, c, td);
        e.name = name;
        e.d    = m_d;
        e.sel  = m_sel;
        e.mode = m_mode;
        q.push_back(e);
    endtask

    task automatic idle(string name, int cycles);
        for (int i = 0; i < cycles; i++) step(name, 1, 0, 0, 0, 0, 0, 0);
    endtask

    // Monitor: every edge produces one registered snapshot to check.
    initial begin
        exp_t e;
        logic [3:0] ed [4];
        bit ok;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                ed[0] = 4'(e.d[0]); ed[1] = 4'(e.d[1]);
                ed[2] = 4'(e.d[2]); ed[3] = 4'(e.d[3]);
                ok = (sec_ones === ed[0]) && (sec_tens === ed[1]) &&
                     (min_ones === ed[2]) && (min_tens === ed[3]) &&
                     (edit_sel === 2'(e.sel)) &&
                     (editing === (e.mode == 0)) && (load === (e.mode == 1)) &&
                     (run_enable === (e.mode == 2)) && (alarm === (e.mode == 3));
                n_tests++;
                if (!ok) begin
                    n_fail++;
                    $display("FAIL %s: got mt=%0d mo=%0d st=%0d so=%0d sel=%0d ed=%b ld=%b run=%b al=%b, need mt=%0d mo=%0d st=%0d so=%0d sel=%0d mode=%0d",
                             e.name, min_tens, min_ones, sec_tens, sec_ones, edit_sel,
                             editing, load, run_enable, alarm,
                             e.d[3], e.d[2], e.d[1], e.d[0], e.sel, e.mode);
                end
            end
        end
    end

    initial begin
        reset = 0; btn_next = 0; btn_up = 0; btn_down = 0;
        btn_start = 0; btn_clear = 0; timer_done = 0;

        step("reset", 0, 0, 0, 0, 0, 0, 0);
        step("reset", 0, 0, 0, 0, 0, 0, 0);

        step("wrap_down_so", 1, 0, 0, 1, 0, 0, 0);
        step("next_sel1", 1, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) step("wrap_up_st", 1, 0, 1, 0, 0, 0, 0);

        step("reset", 0, 0, 0, 0, 0, 0, 0);
        step("start_at_zero", 1, 0, 0, 0, 1, 0, 0);
        idle("no_load_at_zero", 5);

        step("reset", 0, 0, 0, 0, 0, 0, 0);
        step("set_so", 1, 0, 1, 0, 0, 0, 0);
        step("next", 1, 1, 0, 0, 0, 0, 0);
        step("next", 1, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step("set_mo", 1, 0, 1, 0, 0, 0, 0);
        step("start_load", 1, 0, 0, 0, 1, 0, 0);
        step("run_after_load", 1, 0, 1, 1, 1, 0, 0);
        step("run_ignores_btns", 1, 1, 1, 0, 1, 0, 0);

        step("done_to_alarm", 1, 0, 0, 0, 0, 0, 1);
        step("alarm_hold", 1, 1, 1, 0, 0, 0, 1);
        step("ack_to_edit", 1, 0, 0, 0, 1, 0, 0);
        step("done_ignored_edit", 1, 0, 0, 0, 0, 0, 1);

        step("start_load2", 1, 0, 0, 0, 1, 0, 0);
        step("run2", 1, 0, 0, 0, 0, 0, 0);
        step("clear_over_done", 1, 0, 0, 0, 0, 1, 1);
        step("up_over_down", 1, 0, 1, 1, 0, 0, 0);

        step("start_load3", 1, 0, 0, 0, 1, 0, 0);
        step("reset_mid_load", 0, 0, 0, 0, 0, 0, 0);
        step("set_so", 1, 0, 1, 0, 0, 0, 0);
        step("start_load4", 1, 0, 0, 0, 1, 0, 0);
        step("run4", 1, 0, 0, 0, 0, 0, 0);
        step("reset_mid_run", 0, 0, 0, 0, 1, 0, 1);

        for (int i = 0; i < 600; i++) begin
            step("random",
                 ($urandom_range(0, 59) != 0),
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 9) == 0),
                 ($urandom_range(0, 19) == 0), ($urandom_range(0, 5) == 0));
        end

        idle("drain", 1);
        repeat (3) @(posedge clk);
        #2;
        n_tests++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d snapshots unchecked, need 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
